// File: rtl/xillyusb_speedtest.sv
// Speed-test pattern source (read stream) and checker (write stream) for XillyUSB.
// Both sides share one counter/LFSR pattern generator definition.
module xillyusb_speedtest #(
    parameter int ERR_W = 16
) (
    input  logic             bus_clk,
    input  logic             bus_rst,
    input  logic             quiesce,
    input  logic             user_r_read_32_rden,
    input  logic             user_r_read_32_open,
    output logic [31:0]      user_r_read_32_data,
    output logic             user_r_read_32_empty,
    output logic             user_r_read_32_eof,
    input  logic             user_w_write_32_wren,
    input  logic             user_w_write_32_open,
    input  logic [31:0]      user_w_write_32_data,
    output logic             user_w_write_32_full,
    input  logic             pattern_sel,
    input  logic [31:0]      word_limit,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      words_checked,
    output logic             first_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] pat_seed(input logic sel);
        pat_seed = sel ? 32'h0000_0001 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] pat_next(input logic sel, input logic [31:0] cur);
        if (sel) begin
            pat_next = {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
        end else begin
            pat_next = cur + 32'd1;
        end
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       gen_q, gen_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       limit_q, limit_d;
    logic              rsel_q, rsel_d;
    logic [31:0]       data_q, data_d;
    logic              empty_q, empty_d;
    logic              eof_q, eof_d;

    logic              wr_open_q;
    logic              wsel_q, wsel_d;
    logic [31:0]       exp_q, exp_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [31:0]       words_q, words_d;
    logic              first_q, first_d;
    logic              full_q;

    logic              rd_open_s, wr_open_s, rd_fire_s;

    assign rd_open_s = user_r_read_32_open & ~quiesce;
    assign wr_open_s = user_w_write_32_open & ~quiesce;

    // Source FSM next state; empty/eof follow the state with one register stage.
    always_comb begin
        state_d   = state_q;
        gen_d     = gen_q;
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        rsel_d    = rsel_q;
        data_d    = data_q;
        rd_fire_s = (state_q == S_RUN) && !empty_q && user_r_read_32_rden && rd_open_s;
        empty_d   = (state_q != S_RUN);
        eof_d     = (state_q == S_DONE);
        if (!rd_open_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    rsel_d  = pattern_sel;
                    limit_d = word_limit;
                    gen_d   = pat_seed(pattern_sel);
                    cnt_d   = 32'd0;
                end
                S_RUN: begin
                    if (rd_fire_s) begin
                        data_d = gen_q;
                        gen_d  = pat_next(rsel_q, gen_q);
                        cnt_d  = cnt_q + 32'd1;
                        if ((limit_q != 32'd0) && (cnt_d == limit_q)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sink: open edge restarts the check; a mismatch resyncs so one bad word counts once.
    always_comb begin
        wsel_d  = wsel_q;
        exp_d   = exp_q;
        err_d   = err_q;
        words_d = words_q;
        first_d = first_q;
        if (wr_open_s && !wr_open_q) begin
            wsel_d  = pattern_sel;
            exp_d   = pat_seed(pattern_sel);
            err_d   = {ERR_W{1'b0}};
            words_d = 32'd0;
            first_d = 1'b0;
        end else begin
            wsel_d  = wsel_q;
        end
        if (wr_open_s && user_w_write_32_wren) begin
            words_d = words_d + 32'd1;
            if (user_w_write_32_data == exp_d) begin
                exp_d = pat_next(wsel_d, exp_d);
            end else begin
                exp_d   = pat_next(wsel_d, user_w_write_32_data);
                first_d = 1'b1;
                if (err_d != {ERR_W{1'b1}}) begin
                    err_d = err_d + ERR_W'(1'b1);
                end else begin
                    err_d = err_d;
                end
            end
        end else begin
            words_d = words_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q   <= S_IDLE;
            gen_q     <= 32'h0000_0000;
            cnt_q     <= 32'd0;
            limit_q   <= 32'd0;
            rsel_q    <= 1'b0;
            data_q    <= 32'd0;
            empty_q   <= 1'b1;
            eof_q     <= 1'b0;
            wr_open_q <= 1'b0;
            wsel_q    <= 1'b0;
            exp_q     <= 32'h0000_0000;
            err_q     <= {ERR_W{1'b0}};
            words_q   <= 32'd0;
            first_q   <= 1'b0;
            full_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gen_q     <= gen_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            rsel_q    <= rsel_d;
            data_q    <= data_d;
            empty_q   <= empty_d;
            eof_q     <= eof_d;
            wr_open_q <= wr_open_s;
            wsel_q    <= wsel_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            words_q   <= words_d;
            first_q   <= first_d;
            full_q    <= ~wr_open_s;
        end
    end

    assign user_r_read_32_data  = data_q;
    assign user_r_read_32_empty = empty_q;
    assign user_r_read_32_eof   = eof_q;
    assign user_w_write_32_full = full_q;
    assign err_count            = err_q;
    assign words_checked        = words_q;
    assign first_err            = first_q;

endmodule

// File: tb/tb_xillyusb_speedtest.sv
// Directed self-checking bench for xillyusb_speedtest (ERR_W = 4 to reach saturation).
module tb_xillyusb_speedtest;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic        quiesce = 1'b0;
    logic        rden = 1'b0;
    logic        ropen = 1'b0;
    logic [31:0] rdata;
    logic        empty;
    logic        eof;
    logic        wren = 1'b0;
    logic        wopen = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        full;
    logic        psel = 1'b0;
    logic [31:0] wlimit = 32'd0;
    logic [3:0]  err_count;
    logic [31:0] words_checked;
    logic        first_err;

    int checks = 0;
    int errors = 0;

    xillyusb_speedtest #(.ERR_W(4)) dut (
        .bus_clk              (bus_clk),
        .bus_rst              (bus_rst),
        .quiesce              (quiesce),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_open  (ropen),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_empty (empty),
        .user_r_read_32_eof   (eof),
        .user_w_write_32_wren (wren),
        .user_w_write_32_open (wopen),
        .user_w_write_32_data (wdata),
        .user_w_write_32_full (full),
        .pattern_sel          (psel),
        .word_limit           (wlimit),
        .err_count            (err_count),
        .words_checked        (words_checked),
        .first_err            (first_err)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        wren  = 1'b1;
        wdata = d;
        tick();
        wren  = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        check("rst_data", rdata, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_eof", {31'd0, eof}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd1);
        check("rst_err", {28'd0, err_count}, 32'd0);
        check("rst_words", words_checked, 32'd0);
        check("rst_first", {31'd0, first_err}, 32'd0);
        bus_rst = 1'b0;

        // Counter, unlimited
        ropen = 1'b1;
        tick();
        check("open_empty_lat", {31'd0, empty}, 32'd1);
        tick();
        check("open_empty", {31'd0, empty}, 32'd0);
        rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cnt_data", rdata, 32'(i));
            check("cnt_empty", {31'd0, empty}, 32'd0);
            check("cnt_eof", {31'd0, eof}, 32'd0);
        end
        rden = 1'b0;
        ropen = 1'b0;
        tick(); tick();
        check("close_empty", {31'd0, empty}, 32'd1);

        // LFSR
        psel = 1'b1;
        ropen = 1'b1;
        tick(); tick();
        rden = 1'b1;
        tick(); check("lfsr0", rdata, 32'h0000_0001);
        tick(); check("lfsr1", rdata, 32'h0000_0003);
        tick(); check("lfsr2", rdata, 32'h0000_0006);
        tick(); check("lfsr3", rdata, 32'h0000_000D);
        rden = 1'b0;
        ropen = 1'b0;
        psel = 1'b0;
        tick(); tick();

        // Length-limited stream
        wlimit = 32'd3;
        ropen = 1'b1;
        tick(); tick();
        rden = 1'b1;
        tick(); check("lim0", rdata, 32'd0);
        tick(); check("lim1", rdata, 32'd1);
        tick(); check("lim2", rdata, 32'd2);
        tick();
        check("lim_empty", {31'd0, empty}, 32'd1);
        check("lim_eof", {31'd0, eof}, 32'd1);
        check("lim_last", rdata, 32'd2);
        tick(); tick();
        check("lim_hold_data", rdata, 32'd2);
        check("lim_hold_eof", {31'd0, eof}, 32'd1);
        check("lim_hold_empty", {31'd0, empty}, 32'd1);
        rden = 1'b0;
        ropen = 1'b0;
        wlimit = 32'd0;
        tick(); tick();
        check("lim_close_eof", {31'd0, eof}, 32'd0);
        check("lim_close_empty", {31'd0, empty}, 32'd1);

        // Sink, counter pattern with one corrupt word
        wopen = 1'b1;
        tick();
        check("wopen_full", {31'd0, full}, 32'd0);
        wr(32'd0); wr(32'd1); wr(32'd2);
        check("sink_noerr", {28'd0, err_count}, 32'd0);
        wr(32'd7); wr(32'd8);
        check("sink_words", words_checked, 32'd5);
        check("sink_err", {28'd0, err_count}, 32'd1);
        check("sink_first", {31'd0, first_err}, 32'd1);
        wr(32'd9);
        check("sink_resync_err", {28'd0, err_count}, 32'd1);
        check("sink_resync_words", words_checked, 32'd6);
        wren = 1'b1; wdata = 32'd5;
        wopen = 1'b0;
        tick(); tick();
        wren = 1'b0;
        check("closed_wren", words_checked, 32'd6);
        check("closed_full", {31'd0, full}, 32'd1);

        // Saturation, reopen clears statistics
        wopen = 1'b1;
        tick();
        check("reopen_words", words_checked, 32'd0);
        check("reopen_err", {28'd0, err_count}, 32'd0);
        check("reopen_first", {31'd0, first_err}, 32'd0);
        wr(32'd0);
        for (int i = 0; i < 20; i++) wr(32'hFFFF_FFFF);
        check("sat_err", {28'd0, err_count}, 32'd15);
        check("sat_words", words_checked, 32'd21);
        wr(32'hFFFF_FFFF);
        check("sat_hold", {28'd0, err_count}, 32'd15);

        // Quiesce mid-stream
        ropen = 1'b1;
        tick(); tick();
        rden = 1'b1;
        tick(); check("q_rd0", rdata, 32'd0);
        tick(); check("q_rd1", rdata, 32'd1);
        rden = 1'b0;
        quiesce = 1'b1;
        tick(); tick();
        check("q_empty", {31'd0, empty}, 32'd1);
        check("q_full", {31'd0, full}, 32'd1);
        check("q_err_kept", {28'd0, err_count}, 32'd15);
        check("q_words_kept", words_checked, 32'd22);
        quiesce = 1'b0;
        tick(); tick();
        check("q_reopen_empty", {31'd0, empty}, 32'd0);
        rden = 1'b1;
        tick(); check("q_restart0", rdata, 32'd0);
        tick(); check("q_restart1", rdata, 32'd1);

        // Reset mid-stream with stream still open
        bus_rst = 1'b1;
        tick();
        bus_rst = 1'b0;
        check("mrst_data", rdata, 32'd0);
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_words", words_checked, 32'd0);
        tick();
        check("mrst_empty2", {31'd0, empty}, 32'd1);
        tick();
        check("mrst_run", {31'd0, empty}, 32'd0);
        tick(); check("mrst_rd0", rdata, 32'd0);
        tick(); check("mrst_rd1", rdata, 32'd1);
        rden = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xillyusb_speedtest.md
# xillyusb_speedtest

Pattern source and sink for the USB 3.0 speed test, sitting directly downstream of the XillyUSB core on `bus_clk`. It feeds the core's 32-bit read stream (host reads) with an endless or length-limited counter/LFSR pattern. It also consumes the core's 32-bit write stream (host writes), checking every word against the same pattern and keeping error and word statistics. Host-side tools measure throughput; this block guarantees data integrity at line rate.

## Interface
Parameters:
- `ERR_W`, 16, width of the saturating error counter.

Ports:
- `bus_clk`  in  1  core bus clock; the only clock.
- `bus_rst`  in  1  synchronous, active-high reset.
- `quiesce`  in  1  from core; high forces both streams to closed behaviour.
- `user_r_read_32_rden`  in  1  read strobe from core.
- `user_r_read_32_open`  in  1  host has read stream open.
- `user_r_read_32_data`  out  32  pattern word, valid the cycle after `rden`.
- `user_r_read_32_empty`  out  1  no word available.
- `user_r_read_32_eof`  out  1  end of limited stream.
- `user_w_write_32_wren`  in  1  write strobe from core.
- `user_w_write_32_open`  in  1  host has write stream open.
- `user_w_write_32_data`  in  32  word to check.
- `user_w_write_32_full`  out  1  back-pressure to core.
- `pattern_sel`  in  1  0 = counter, 1 = LFSR; latched at stream open.
- `word_limit`  in  32  read stream length in words; 0 = unlimited; latched at open.
- `err_count`  out  ERR_W  saturating mismatch count.
- `words_checked`  out  32  words received on the write stream, wrapping.
- `first_err`  out  1  sticky; set on the first mismatch since write open.

## Operation
- Pattern functions:
  - Counter: seed 0x00000000, next = cur + 1 mod 2^32.
  - LFSR: seed 0x00000001, next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
- "Open" means `open & ~quiesce`.
- Source FSM, states IDLE / RUN / DONE:
  - IDLE: `empty`=1, `eof`=0. Moves to RUN when the read stream is open. On that transition it latches `pattern_sel` and `word_limit`, loads the generator with the seed, and clears the word count.
  - RUN: `empty`=0. On `rden`, `data` is registered with the current generator value, the generator advances, and the count increments. When `word_limit`≠0 and the incremented count equals `word_limit`, the FSM moves to DONE.
  - DONE: `empty`=1, `eof`=1. Both are held until the stream closes.
  - From any state, a closed stream returns the FSM to IDLE.
  - `rden` while `empty`=1 is ignored: no advance, and `data` holds its value.
- Sink, on write-stream open edge:
  - Latches `pattern_sel`.
  - Sets expected = seed.
  - Clears `err_count`, `words_checked` and `first_err`.
- Sink, on each `wren` while open:
  - `words_checked` increments.
  - On `data` == expected: expected <= next(expected).
  - On mismatch: `err_count` increments and saturates at all-ones; `first_err` is set; expected resyncs to next(data). A single corrupt word therefore counts once.
- `wren` while not open is ignored.
- `user_w_write_32_full` is registered: full <= ~(write open). The sink accepts one word per cycle and never back-pressures while open.
- `quiesce` high: both sides behave as closed. The statistics retain their values until the next write-open edge or reset.

## Timing
- Reset values:
  - `data` = 0, `empty` = 1, `eof` = 0, `full` = 1.
  - `err_count` = 0, `words_checked` = 0, `first_err` = 0.
  - Source FSM = IDLE; both generators = counter seed.
- Open sampled high at edge N: `empty` low after edge N+1.
- Sustained `rden` produces one word per cycle with no bubbles.
- `data` updates at the edge following the `rden` cycle.
- Limit reached by the `rden` at edge N: `empty` and `eof` are both high after edge N+1. The last word is valid in the same cycle.
- Close at edge N: `empty`=1 and `eof`=0 after edge N+1. Reopening restarts from the seed.
- Statistics update one cycle after `wren`.
- `bus_rst` mid-stream forces the reset values at the next edge. If the stream is still open afterwards, the source re-enters RUN one cycle later and restarts from the seed.

## Test plan
- Counter, unlimited: open the read stream, assert `rden` for 4 consecutive cycles -> `data` = 0,1,2,3 on successive cycles; `empty` stays 0; `eof` stays 0.
- LFSR: `pattern_sel`=1, open, 4 reads -> `data` = 0x00000001, 0x00000003, 0x00000006, 0x0000000D.
- Limit: `word_limit`=3, continuous `rden` -> 3 words 0,1,2, then `empty`=1 and `eof`=1 held. Further `rden` does not change `data`. Closing gives `eof`=0.
- Sink, counter: write 0,1,2,7,8 -> `words_checked`=5, `err_count`=1, `first_err`=1. A further write of 9 adds no error.
- Saturation, with `ERR_W`=4: write 20 wrong words (expected ≠ data every time, e.g. constant 0xFFFFFFFF after 0) -> `err_count`=15 and holds.
- Close/quiesce mid-stream: after 2 reads, pulse `quiesce` -> `empty`=1 next cycle. Deassert `quiesce` -> reads restart at 0. `full`=1 during quiesce and statistics are retained.
